// File: rtl/decompress_core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decompress_core_pkg
//  Description : Shared types, field positions and helpers for the run-length
//                decompressor.
//  Revision    : 1.0
// ============================================================================
package decompress_core_pkg;

    localparam int BYTE_W  = 8;
    localparam int POS_W   = 3;
    localparam int IDX_W   = 4;
    localparam int CNT_W   = 32;
    localparam int CODE_W  = 3;
    localparam int VAL_BIT = 2;
    localparam int LEN_MSB = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN1   = 2'd1,
        RUN2   = 2'd2,
        FINISH = 2'd3
    } state_t;

    function automatic logic [LEN_MSB:0] code_len(input logic [CODE_W-1:0] code);
        return code[LEN_MSB:0];
    endfunction

    function automatic logic code_val(input logic [CODE_W-1:0] code);
        return code[VAL_BIT];
    endfunction

endpackage
`default_nettype wire

// File: rtl/decompress_core_run_writer.sv
`default_nettype none
// ============================================================================
//  Module      : run_writer
//  Description : Returns a byte with one bit position optionally overwritten.
//  Revision    : 1.0
// ============================================================================
module run_writer
    import decompress_core_pkg::*;
(
    input  logic [BYTE_W-1:0] din,
    input  logic [POS_W-1:0]  pos,
    input  logic              val,
    input  logic              en,
    output logic [BYTE_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (en) begin
            dout[pos] = val;
        end
    end

endmodule
`default_nettype wire

// File: rtl/decompress_core.sv
`default_nettype none
// ============================================================================
//  Module      : decompress_core
//  Description : Expands two 3-bit run codes into one byte, MSB first.
//  Revision    : 1.0
// ============================================================================
module decompress_core
    import decompress_core_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] in1,
    input  logic [CODE_W-1:0] in2,
    input  logic              work,
    output logic [BYTE_W-1:0] out,
    output logic [CNT_W-1:0]  byteIndx,
    output logic [IDX_W-1:0]  bitIndx,
    output logic              done
);

    localparam logic [POS_W-1:0] c_top_pos = POS_W'(BYTE_W - 1);

    state_t              r_state;
    logic [CODE_W-1:0]   r_code1;
    logic [CODE_W-1:0]   r_code2;
    logic [LEN_MSB:0]    r_cnt;
    logic [BYTE_W-1:0]   r_out;
    logic [IDX_W-1:0]    r_bit_idx;
    logic [CNT_W-1:0]    r_byte_idx;
    logic                r_done;

    state_t              w_state_nxt;
    logic [CODE_W-1:0]   w_code1_nxt;
    logic [CODE_W-1:0]   w_code2_nxt;
    logic [LEN_MSB:0]    w_cnt_nxt;
    logic [BYTE_W-1:0]   w_out_nxt;
    logic [IDX_W-1:0]    w_bit_nxt;
    logic [CNT_W-1:0]    w_byte_nxt;
    logic                w_done_nxt;

    logic [CODE_W-1:0]   w_cur_code;
    logic                w_run_left;
    logic                w_wr_en;
    logic [POS_W-1:0]    w_pos;
    logic [BYTE_W-1:0]   w_out_wr;

    // Both run states drive the same writer; the active code selects the value.
    assign w_cur_code = (r_state == RUN2) ? r_code2 : r_code1;
    assign w_run_left = (r_cnt != code_len(w_cur_code));
    assign w_wr_en    = ((r_state == RUN1) || (r_state == RUN2)) && w_run_left;
    assign w_pos      = c_top_pos - r_bit_idx[POS_W-1:0];

    run_writer u_run_writer (
        .din  (r_out),
        .pos  (w_pos),
        .val  (code_val(w_cur_code)),
        .en   (w_wr_en),
        .dout (w_out_wr)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_code1_nxt = r_code1;
        w_code2_nxt = r_code2;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        w_bit_nxt   = r_bit_idx;
        w_byte_nxt  = r_byte_idx;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (work) begin
                    w_code1_nxt = in1;
                    w_code2_nxt = in2;
                    w_out_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = RUN1;
                end
            end
            RUN1, RUN2: begin
                if (w_run_left) begin
                    w_out_nxt = w_out_wr;
                    w_bit_nxt = r_bit_idx + 4'd1;
                    w_cnt_nxt = r_cnt + 2'd1;
                end else begin
                    // Exhausted run costs one cycle, which is also how a zero-length run passes.
                    w_cnt_nxt   = '0;
                    w_state_nxt = (r_state == RUN1) ? RUN2 : FINISH;
                end
            end
            FINISH: begin
                w_done_nxt  = 1'b1;
                w_byte_nxt  = r_byte_idx + 32'd1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_code1    <= '0;
            r_code2    <= '0;
            r_cnt      <= '0;
            r_out      <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_code1    <= w_code1_nxt;
            r_code2    <= w_code2_nxt;
            r_cnt      <= w_cnt_nxt;
            r_out      <= w_out_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_byte_idx <= w_byte_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign out      = r_out;
    assign byteIndx = r_byte_idx;
    assign bitIndx  = r_bit_idx;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_decompress_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decompress_core
//  Description : Self-checking bench for decompress_core against a run model.
//  Revision    : 1.0
// ============================================================================
module tb_decompress_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  in1 = '0;
    logic [2:0]  in2 = '0;
    logic        work = 1'b0;
    logic [7:0]  out;
    logic [31:0] byteIndx;
    logic [3:0]  bitIndx;
    logic        done;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_byte = '0;
    logic [7:0]  exp_out = '0;
    logic [3:0]  exp_bit = '0;
    bit          mon_en = 1'b0;
    int          done_cnt = 0;

    decompress_core dut (
        .clk      (clk),
        .rst      (rst),
        .in1      (in1),
        .in2      (in2),
        .work     (work),
        .out      (out),
        .byteIndx (byteIndx),
        .bitIndx  (bitIndx),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en && done === 1'b1) done_cnt++;
    end

    // Fill MSB-first: len1 copies of value1, then len2 copies of value2.
    function automatic logic [7:0] model_byte(input logic [2:0] a, input logic [2:0] b);
        logic [7:0] r = '0;
        int p = 7;
        for (int i = 0; i < int'(a[1:0]); i++) begin r[p] = a[2]; p--; end
        for (int i = 0; i < int'(b[1:0]); i++) begin r[p] = b[2]; p--; end
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] a, input logic [2:0] b);
        return int'(a[1:0]) + int'(b[1:0]) + 3;
    endfunction

    task automatic do_txn(input logic [2:0] a, input logic [2:0] b, input bit hold, output int lat);
        in1 = a; in2 = b; work = 1'b1;
        @(posedge clk); #1;
        if (!hold) work = 1'b0;
        in1 = 3'($urandom); in2 = 3'($urandom);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; work = 1'b1; in1 = 3'b011; in2 = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out !== 8'h00) begin errors++; $display("FAIL reset_out: got %b expected %b", out, 8'h00); end
        checks++; if (byteIndx !== 32'd0) begin errors++; $display("FAIL reset_byte: got %0d expected 0", byteIndx); end
        checks++; if (bitIndx !== 4'd0) begin errors++; $display("FAIL reset_bit: got %0d expected 0", bitIndx); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        rst = 1'b0; work = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bitIndx !== 4'd0 || done !== 1'b0) begin errors++; $display("FAIL idle_after_reset: bit=%0d done=%b expected 0/0", bitIndx, done); end
    endtask

    task automatic test_vectors();
        logic [2:0] ta [4] = '{3'b001, 3'b010, 3'b011, 3'b000};
        logic [2:0] tb [4] = '{3'b101, 3'b111, 3'b111, 3'b100};
        int lat;
        for (int k = 0; k < 4; k++) begin
            do_txn(ta[k], tb[k], 1'b0, lat);
            exp_byte = exp_byte + 32'd1;
            exp_out  = model_byte(ta[k], tb[k]);
            exp_bit  = 4'(ta[k][1:0] + tb[k][1:0]);
            checks++; if (lat != model_lat(ta[k], tb[k])) begin errors++; $display("FAIL vec%0d_latency: got %0d expected %0d", k, lat, model_lat(ta[k], tb[k])); end
            checks++; if (out !== exp_out) begin errors++; $display("FAIL vec%0d_out: got %b expected %b", k, out, exp_out); end
            checks++; if (bitIndx !== exp_bit) begin errors++; $display("FAIL vec%0d_bit: got %0d expected %0d", k, bitIndx, exp_bit); end
            checks++; if (byteIndx !== exp_byte) begin errors++; $display("FAIL vec%0d_byte: got %0d expected %0d", k, byteIndx, exp_byte); end
        end
    endtask

    task automatic test_hold_after_done();
        work = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in1 = 3'($urandom); in2 = 3'($urandom);
            @(posedge clk); #1;
            checks++; if (out !== exp_out || bitIndx !== exp_bit) begin errors++; $display("FAIL hold%0d_outbit: got %b/%0d expected %b/%0d", k, out, bitIndx, exp_out, exp_bit); end
            checks++; if (done !== 1'b0 || byteIndx !== exp_byte) begin errors++; $display("FAIL hold%0d_done_byte: got %b/%0d expected 0/%0d", k, done, byteIndx, exp_byte); end
        end
    endtask

    task automatic test_random();
        logic [2:0] a, b;
        int lat;
        for (int k = 0; k < 20; k++) begin
            a = 3'($urandom); b = 3'($urandom);
            do_txn(a, b, 1'b0, lat);
            exp_byte = exp_byte + 32'd1;
            exp_out  = model_byte(a, b);
            exp_bit  = 4'(a[1:0] + b[1:0]);
            checks++; if (lat != model_lat(a, b)) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", k, lat, model_lat(a, b)); end
            checks++; if (out !== exp_out) begin errors++; $display("FAIL rnd%0d_out: got %b expected %b (in1=%b in2=%b)", k, out, exp_out, a, b); end
            checks++; if (bitIndx !== exp_bit) begin errors++; $display("FAIL rnd%0d_bit: got %0d expected %0d", k, bitIndx, exp_bit); end
            checks++; if (byteIndx !== exp_byte) begin errors++; $display("FAIL rnd%0d_byte: got %0d expected %0d", k, byteIndx, exp_byte); end
            checks++; if (out[1:0] !== 2'b00) begin errors++; $display("FAIL rnd%0d_lowbits: got %b expected 00", k, out[1:0]); end
            @(posedge clk); #1;
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL rnd%0d_pulse: got %b expected 0", k, done); end
        end
    endtask

    task automatic test_reset_midrun();
        int lat;
        in1 = 3'b011; in2 = 3'b111; work = 1'b1;
        @(posedge clk); #1;
        work = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_byte = '0;
        checks++; if (out !== 8'h00 || bitIndx !== 4'd0) begin errors++; $display("FAIL midrst_outbit: got %b/%0d expected 0/0", out, bitIndx); end
        checks++; if (byteIndx !== 32'd0 || done !== 1'b0) begin errors++; $display("FAIL midrst_byte_done: got %0d/%b expected 0/0", byteIndx, done); end
        repeat (8) @(posedge clk);
        #1;
        checks++; if (out !== 8'h00 || bitIndx !== 4'd0 || byteIndx !== 32'd0) begin errors++; $display("FAIL midrst_stays_idle: got %b/%0d/%0d expected 0/0/0", out, bitIndx, byteIndx); end
        do_txn(3'b001, 3'b110, 1'b0, lat);
        exp_byte = 32'd1;
        exp_out  = model_byte(3'b001, 3'b110);
        exp_bit  = 4'd3;
        checks++; if (out !== exp_out) begin errors++; $display("FAIL midrst_next_out: got %b expected %b", out, exp_out); end
        checks++; if (byteIndx !== exp_byte) begin errors++; $display("FAIL midrst_next_byte: got %0d expected %0d", byteIndx, exp_byte); end
        checks++; if (lat != model_lat(3'b001, 3'b110)) begin errors++; $display("FAIL midrst_next_latency: got %0d expected %0d", lat, model_lat(3'b001, 3'b110)); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] a, b;
        int lat;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_byte = '0;
        done_cnt = 0;
        mon_en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            a = 3'($urandom); b = 3'($urandom);
            do_txn(a, b, 1'b1, lat);
            exp_byte = exp_byte + 32'd1;
            exp_out  = model_byte(a, b);
            exp_bit  = 4'(a[1:0] + b[1:0]);
            checks++; if (lat != model_lat(a, b)) begin errors++; $display("FAIL b2b%0d_latency: got %0d expected %0d", k, lat, model_lat(a, b)); end
            checks++; if (out !== exp_out || bitIndx !== exp_bit) begin errors++; $display("FAIL b2b%0d_outbit: got %b/%0d expected %b/%0d", k, out, bitIndx, exp_out, exp_bit); end
            checks++; if (byteIndx !== exp_byte) begin errors++; $display("FAIL b2b%0d_byte: got %0d expected %0d", k, byteIndx, exp_byte); end
        end
        work = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        mon_en = 1'b0;
        checks++; if (done_cnt != 9) begin errors++; $display("FAIL b2b_done_pulses: got %0d expected 9", done_cnt); end
        checks++; if (byteIndx !== 32'd9) begin errors++; $display("FAIL b2b_final_byte: got %0d expected 9", byteIndx); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_hold_after_done();
        test_random();
        test_reset_midrun();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
